// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding, default frame parameters
// and a counter-width helper reused by the transmitter and receiver.
package uart_defs;

   localparam int unsigned DEF_WORD         = 8;
   localparam int unsigned DEF_CLKS_PER_BIT = 16;
   localparam int unsigned DEF_STOP_BITS    = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO-read and serial-line signal bundle for fifo_uart_tx.
// The master side feeds the FIFO head; the slave side is the transmitter.
interface fifo_uart_tx_if
   import uart_defs::*;
#(
   parameter int unsigned WORD = DEF_WORD
);

   logic            empty;
   logic [WORD-1:0] data;
   logic            read;
   logic            tx;
   logic            busy;
   logic            done;

   modport master (
      output empty,
      output data,
      input  read,
      input  tx,
      input  busy,
      input  done
   );

   modport slave (
      input  empty,
      input  data,
      output read,
      output tx,
      output busy,
      output done
   );

endinterface

// File: rtl/tx_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while running, wraps at each
// bit boundary and is cleared by start.
module tx_bit_timer
   import uart_defs::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic run,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int unsigned   CW       = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // bit_end must not depend on start: start is derived from bit_end upstream
   assign bit_end     = run && (cnt_q == CNT_LAST);
   assign bit_pre_end = run && (cnt_q == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a first-word-fall-through FIFO: pops one word
// per frame, sends start/data(LSB first)/stop bits, chains frames gaplessly.
module fifo_uart_tx
   import uart_defs::*;
#(
   parameter int unsigned WORD         = DEF_WORD,
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned STOP_BITS    = DEF_STOP_BITS
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_empty,
   input  logic [WORD-1:0] i_data,
   output logic            o_read,
   output logic            o_tx,
   output logic            o_busy,
   output logic            o_done
);

   localparam int unsigned   IW        = cnt_width(WORD);
   localparam logic [IW-1:0] IDX_LAST  = IW'(WORD - 1);
   localparam logic          STOP_LAST = (STOP_BITS > 1);

   uart_state_e     state_q, state_d;
   logic [WORD-1:0] shreg_q, shreg_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            stop_cnt_q, stop_cnt_d;
   logic            tx_q, tx_d;
   logic            done_q, done_d;

   logic            run;
   logic            bit_end;
   logic            bit_pre_end;
   logic            last_stop;
   logic            fetch;

   assign run       = (state_q != IDLE);
   assign last_stop = (state_q == STOP) && (stop_cnt_q == STOP_LAST) && bit_end;
   // Gated by reset so the pop strobe stays low while held in reset
   assign fetch     = i_reset && !i_empty && ((state_q == IDLE) || last_stop);

   tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk        (i_clock),
      .rst_n      (i_reset),
      .start      (fetch),
      .run        (run),
      .bit_end    (bit_end),
      .bit_pre_end(bit_pre_end)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      idx_d      = idx_q;
      stop_cnt_d = stop_cnt_q;
      case (state_q)
         IDLE: begin
            if (fetch) begin
               shreg_d = i_data;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = STOP;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shreg_d = shreg_q >> 1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == STOP_LAST) begin
                  stop_cnt_d = 1'b0;
                  if (fetch) begin
                     shreg_d = i_data;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line level follows the next state so the registered output lines up
   // with the state it belongs to; o_done is predicted one cycle early so
   // the registered pulse lands on the final stop cycle.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         default: tx_d = 1'b1;
      endcase
      done_d = (state_q == STOP) && (stop_cnt_q == STOP_LAST) && bit_pre_end;
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         idx_q      <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         idx_q      <= idx_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   assign o_read = fetch;
   assign o_tx   = tx_q;
   assign o_busy = run;
   assign o_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (WORD=8, CLKS_PER_BIT=4) with a queue of
// expected words checked against the decoded serial line.
module tb_fifo_uart_tx;
   import uart_defs::*;

   localparam int unsigned W   = 8;
   localparam int unsigned CPB = 4;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b1;
   int           checks   = 0;
   int           errors   = 0;
   int           read_cnt = 0;
   logic [W-1:0] exp_q[$];

   fifo_uart_tx_if #(.WORD(W)) bus1 ();
   fifo_uart_tx_if #(.WORD(W)) bus2 ();

   fifo_uart_tx #(
      .WORD        (W),
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (1)
   ) dut (
      .i_clock(clk),
      .i_reset(rst_n),
      .i_empty(bus1.empty),
      .i_data (bus1.data),
      .o_read (bus1.read),
      .o_tx   (bus1.tx),
      .o_busy (bus1.busy),
      .o_done (bus1.done)
   );

   fifo_uart_tx #(
      .WORD        (W),
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (2)
   ) dut2 (
      .i_clock(clk),
      .i_reset(rst_n),
      .i_empty(bus2.empty),
      .i_data (bus2.data),
      .o_read (bus2.read),
      .o_tx   (bus2.tx),
      .o_busy (bus2.busy),
      .o_done (bus2.done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus1.read === 1'b1) read_cnt <= read_cnt + 1;
   end

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Entered in cycle 0 (the o_read cycle); walks cycles 1..40 of one frame.
   task automatic frame1(input logic [W-1:0] head_after, input logic empty_after);
      logic [W-1:0] exp_w;
      logic [W-1:0] rx_w;
      logic [W-1:0] tmp;
      logic         exp_tx;
      int           bad_tx, bad_busy, bad_done, bad_read;
      bad_tx   = 0;
      bad_busy = 0;
      bad_done = 0;
      bad_read = 0;
      rx_w     = '0;
      exp_w    = 'x;
      check_bit("sb_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus1.data  = head_after;
            bus1.empty = empty_after;
         end
         #1;
         if (i <= 4) begin
            exp_tx = 1'b0;
         end else if (i <= 36) begin
            tmp    = exp_w >> ((i - 5) / 4);
            exp_tx = tmp[0];
         end else begin
            exp_tx = 1'b1;
         end
         if (bus1.tx !== exp_tx) bad_tx++;
         if (bus1.busy !== 1'b1) bad_busy++;
         if (bus1.done !== (i == 40)) bad_done++;
         if (bus1.read !== ((i == 40) && !empty_after)) bad_read++;
         if (i >= 7 && i <= 35 && ((i - 7) % 4) == 0) rx_w = {bus1.tx, rx_w[W-1:1]};
      end
      check_val("frame_tx_cycles", bad_tx, 0);
      check_val("frame_busy_cycles", bad_busy, 0);
      check_val("frame_done_cycle40", bad_done, 0);
      check_val("frame_read_window", bad_read, 0);
      check_val("scoreboard_word", 32'(rx_w), 32'(exp_w));
   endtask

   initial begin
      int rc;
      int bad;
      int done_at;
      int stop_len;

      bus1.empty = 1'b0;
      bus1.data  = 8'h5A;
      bus2.empty = 1'b1;
      bus2.data  = '0;

      // Reset: asynchronous, outputs forced even with a word available
      #2 rst_n = 1'b0;
      #1;
      check_bit("rst_tx", bus1.tx, 1'b1);
      check_bit("rst_busy", bus1.busy, 1'b0);
      check_bit("rst_done", bus1.done, 1'b0);
      check_bit("rst_read", bus1.read, 1'b0);
      check_bit("rst_tx2", bus2.tx, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      check_bit("rst_read_clocked", bus1.read, 1'b0);
      check_bit("rst_busy_clocked", bus1.busy, 1'b0);
      bus1.empty = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_bit("idle_tx", bus1.tx, 1'b1);
      check_bit("idle_busy", bus1.busy, 1'b0);

      // Single word 8'hA5
      @(negedge clk);
      rc = read_cnt;
      bus1.data  = 8'hA5;
      bus1.empty = 1'b0;
      exp_q.push_back(8'hA5);
      #1 check_bit("a5_read_c0", bus1.read, 1'b1);
      frame1(8'hA5, 1'b1);
      @(negedge clk);
      #1;
      check_bit("a5_busy_fall_c41", bus1.busy, 1'b0);
      check_bit("a5_tx_idle_c41", bus1.tx, 1'b1);
      check_val("a5_read_count", read_cnt - rc, 1);

      // Back-to-back 8'h01 then 8'h02
      repeat (2) @(negedge clk);
      rc = read_cnt;
      bus1.data  = 8'h01;
      bus1.empty = 1'b0;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      #1 check_bit("b2b_read_c0", bus1.read, 1'b1);
      frame1(8'h02, 1'b0);
      frame1(8'h02, 1'b1);
      repeat (5) @(negedge clk);
      check_val("b2b_read_count", read_cnt - rc, 2);

      // Data hold: head changes after capture
      @(negedge clk);
      bus1.data  = 8'h3C;
      bus1.empty = 1'b0;
      exp_q.push_back(8'h3C);
      #1 check_bit("hold_read_c0", bus1.read, 1'b1);
      frame1(8'hFF, 1'b1);

      // Empty FIFO for 200 cycles
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (bus1.read !== 1'b0 || bus1.tx !== 1'b1 || bus1.busy !== 1'b0) bad++;
      end
      check_val("empty_quiet", bad, 0);

      // Reset during data bit 3 of 8'hFF
      @(negedge clk);
      bus1.data  = 8'hFF;
      bus1.empty = 1'b0;
      #1 check_bit("rst_mid_read_c0", bus1.read, 1'b1);
      @(negedge clk) bus1.empty = 1'b1;
      repeat (17) @(negedge clk);
      #1 check_bit("rst_mid_busy_before", bus1.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_bit("rst_mid_tx", bus1.tx, 1'b1);
      check_bit("rst_mid_busy", bus1.busy, 1'b0);
      check_bit("rst_mid_done", bus1.done, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rc  = read_cnt;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (bus1.read !== 1'b0 || bus1.tx !== 1'b1 || bus1.busy !== 1'b0) bad++;
      end
      check_val("rst_mid_no_frame", bad, 0);
      check_val("rst_mid_no_refetch", read_cnt - rc, 0);

      // Normal frame after the mid-frame reset
      @(negedge clk);
      bus1.data  = 8'h96;
      bus1.empty = 1'b0;
      exp_q.push_back(8'h96);
      #1 check_bit("post_rst_read_c0", bus1.read, 1'b1);
      frame1(8'h96, 1'b1);

      // Two stop bits, 8'h00
      @(negedge clk);
      bus2.data  = 8'h00;
      bus2.empty = 1'b0;
      #1 check_bit("s2_read_c0", bus2.read, 1'b1);
      bad      = 0;
      done_at  = -1;
      stop_len = 0;
      for (int i = 1; i <= 46; i++) begin
         @(negedge clk);
         if (i == 1) bus2.empty = 1'b1;
         #1;
         if (bus2.tx !== (i >= 37)) bad++;
         if (bus2.busy !== (i <= 44)) bad++;
         if (bus2.read !== 1'b0) bad++;
         if (bus2.done === 1'b1) begin
            if (done_at < 0) done_at = i;
            else bad++;
         end
         if (i >= 37 && bus2.busy === 1'b1 && bus2.tx === 1'b1) stop_len++;
      end
      check_val("s2_shape", bad, 0);
      check_val("s2_done_cycle", done_at, 44);
      check_val("s2_stop_len", stop_len, 8);

      check_val("sb_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
